// File: rtl/fht_pingpong_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fht_defines : shared constants and FSM encodings for the FHT sequencer      |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
package fht_defines;

  localparam int c_A_BIT_DEF   = 8;
  localparam int c_ST_NUM_DEF  = 5;
  localparam int c_STG_BIT_DEF = 3;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_GAP  = 2'd2;
  localparam logic [1:0] c_FIN  = 2'd3;

  // Four banks of 2^aBit words each.
  function automatic int frameLen(input int aBit);
    return 4 * (1 << aBit);
  endfunction

  localparam int c_FRAME_DEF = frameLen(c_A_BIT_DEF);

endpackage
`default_nettype wire

// File: rtl/fht_load_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fht_load_cnt : saturating frame-load counter with clear and loaded flag    |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module fht_load_cnt
  import fht_defines::*;
#(
  parameter int A_BIT = c_A_BIT_DEF
) (
  input  logic iCLK,
  input  logic iRESET,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_loaded
);

  localparam int               FRAME  = frameLen(A_BIT);
  localparam logic [A_BIT+2:0] c_FULL = (A_BIT + 3)'(FRAME);

  logic [A_BIT+2:0] r_count;
  logic [A_BIT+2:0] w_countNext;
  logic             r_loaded;

  always_comb begin
    w_countNext = r_count;
    if (i_clr)
      w_countNext = '0;
    else if (i_inc && (r_count != c_FULL))
      w_countNext = r_count + 1'b1;
  end

  // Flag is registered alongside the count so it lines up with it.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_count  <= '0;
      r_loaded <= 1'b0;
    end else begin
      r_count  <= w_countNext;
      r_loaded <= (w_countNext == c_FULL);
    end
  end

  assign o_loaded = r_loaded;

endmodule
`default_nettype wire

// File: rtl/fht_pingpong_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fht_pingpong_ctrl : FHT frame sequencer owning the A/B ping-pong RAMs      |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module fht_pingpong_ctrl
  import fht_defines::*;
#(
  parameter int A_BIT   = c_A_BIT_DEF,
  parameter int ST_NUM  = c_ST_NUM_DEF,
  parameter int STG_BIT = c_STG_BIT_DEF
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iWE,
  input  logic               iSTART,
  input  logic               iSTAGE_DONE,
  input  logic               iENG_WE,
  output logic               oWE_A,
  output logic               oWE_B,
  output logic               oSRC_B,
  output logic               oRD_SEL_B,
  output logic [STG_BIT-1:0] oSTAGE,
  output logic               oST_ZERO,
  output logic               oST_LAST,
  output logic               oSTAGE_START,
  output logic               oBUSY,
  output logic               oLOADED,
  output logic               oRES_VALID,
  output logic               oERR,
  output logic               oRDY
);

  localparam logic [STG_BIT-1:0] c_LAST_STAGE = STG_BIT'(ST_NUM - 1);
  localparam logic               c_RD_SEL_B   = ((ST_NUM % 2) != 0);

  logic [1:0]         r_state;
  logic [1:0]         w_stateNext;
  logic [STG_BIT-1:0] r_stage;
  logic               r_stageStart;
  logic               r_err;
  logic               r_resValid;
  logic               r_rdSelB;
  logic               w_idle;
  logic               w_run;
  logic               w_gap;
  logic               w_fin;
  logic               w_busy;
  logic               w_loaded;
  logic               w_load;
  logic               w_lastStage;

  assign w_idle      = (r_state == c_IDLE);
  assign w_run       = (r_state == c_RUN);
  assign w_gap       = (r_state == c_GAP);
  assign w_fin       = (r_state == c_FIN);
  assign w_busy      = w_run | w_gap;
  assign w_lastStage = (r_stage == c_LAST_STAGE);
  assign w_load      = w_idle & iWE;

  fht_load_cnt #(
    .A_BIT (A_BIT)
  ) u_loadCnt (
    .iCLK     (iCLK),
    .iRESET   (iRESET),
    .i_inc    (w_load),
    .i_clr    (w_fin),
    .o_loaded (w_loaded)
  );

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET)
      r_state <= c_IDLE;
    else
      r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      c_IDLE:  if (iSTART && w_loaded) w_stateNext = c_RUN;
      c_RUN:   if (iSTAGE_DONE) w_stateNext = w_lastStage ? c_FIN : c_GAP;
      c_GAP:   w_stateNext = c_RUN;
      c_FIN:   w_stateNext = c_IDLE;
      default: w_stateNext = c_IDLE;
    endcase
  end

  // Any write strobe outside IDLE would be lost, so it is flagged.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_stage      <= '0;
      r_stageStart <= 1'b0;
      r_err        <= 1'b0;
      r_resValid   <= 1'b0;
      r_rdSelB     <= 1'b0;
    end else begin
      r_stageStart <= (w_idle & iSTART & w_loaded) | w_gap;
      r_err        <= (w_idle & iSTART & ~w_loaded) | (~w_idle & iWE);
      if (w_gap)
        r_stage <= r_stage + 1'b1;
      else if (w_fin)
        r_stage <= '0;
      if (w_fin) begin
        r_resValid <= 1'b1;
        r_rdSelB   <= c_RD_SEL_B;
      end else if (w_load) begin
        r_resValid <= 1'b0;
      end
    end
  end

  // Destination block is always the one the engine is not reading.
  always_comb begin
    oWE_A        = ~iRESET & ((w_idle & iWE) | (w_run & iENG_WE & r_stage[0]));
    oWE_B        = ~iRESET & w_run & iENG_WE & ~r_stage[0];
    oSRC_B       = w_busy & r_stage[0];
    oRD_SEL_B    = r_rdSelB;
    oSTAGE       = r_stage;
    oST_ZERO     = w_busy & (r_stage == '0);
    oST_LAST     = w_busy & w_lastStage;
    oSTAGE_START = r_stageStart;
    oBUSY        = w_busy;
    oLOADED      = w_loaded;
    oRES_VALID   = r_resValid;
    oERR         = r_err;
    oRDY         = w_fin;
  end

endmodule
`default_nettype wire

// File: tb/tb_fht_pingpong_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fht_pingpong_ctrl : scoreboard bench with a behavioural sequencer model |
// | Revision             : 1.0                                                 |
// +----------------------------------------------------------------------------+
module tb_fht_pingpong_ctrl;

  localparam int A_BIT   = 2;
  localparam int ST_NUM  = 3;
  localparam int STG_BIT = 2;
  localparam int FRAME   = 4 * (1 << A_BIT);

  logic               clk = 1'b0;
  logic               iRESET = 1'b0;
  logic               iWE = 1'b0;
  logic               iSTART = 1'b0;
  logic               iSTAGE_DONE = 1'b0;
  logic               iENG_WE = 1'b0;
  logic               oWE_A, oWE_B, oSRC_B, oRD_SEL_B;
  logic [STG_BIT-1:0] oSTAGE;
  logic               oST_ZERO, oST_LAST, oSTAGE_START, oBUSY;
  logic               oLOADED, oRES_VALID, oERR, oRDY;

  always #5 clk = ~clk;

  fht_pingpong_ctrl #(
    .A_BIT   (A_BIT),
    .ST_NUM  (ST_NUM),
    .STG_BIT (STG_BIT)
  ) dut (
    .iCLK         (clk),
    .iRESET       (iRESET),
    .iWE          (iWE),
    .iSTART       (iSTART),
    .iSTAGE_DONE  (iSTAGE_DONE),
    .iENG_WE      (iENG_WE),
    .oWE_A        (oWE_A),
    .oWE_B        (oWE_B),
    .oSRC_B       (oSRC_B),
    .oRD_SEL_B    (oRD_SEL_B),
    .oSTAGE       (oSTAGE),
    .oST_ZERO     (oST_ZERO),
    .oST_LAST     (oST_LAST),
    .oSTAGE_START (oSTAGE_START),
    .oBUSY        (oBUSY),
    .oLOADED      (oLOADED),
    .oRES_VALID   (oRES_VALID),
    .oERR         (oERR),
    .oRDY         (oRDY)
  );

  // Order: weA weB srcB rdSel stage[1:0] stZero stLast stStart busy loaded resValid err rdy
  typedef logic [14:0] outVec_t;

  outVec_t expQ[$];
  int      nCmp = 0;
  int      nMis = 0;
  int      cyc  = 0;

  // Behavioural model: phase 0 idle, 1 stage running, 2 between stages, 3 finishing.
  int   mPhase = 0;
  int   mWords = 0;
  int   mStage = 0;
  logic mResV  = 1'b0;
  logic mRdSel = 1'b0;
  logic mErr   = 1'b0;
  logic mLaunch = 1'b0;

  function automatic outVec_t packDut();
    return {oWE_A, oWE_B, oSRC_B, oRD_SEL_B, oSTAGE, oST_ZERO, oST_LAST,
            oSTAGE_START, oBUSY, oLOADED, oRES_VALID, oERR, oRDY};
  endfunction

  task automatic step(input logic we, input logic st, input logic dn,
                      input logic eng, input logic rs);
    outVec_t e;
    logic    busy, odd, nErr, nLaunch;
    logic [1:0] stg;
    @(posedge clk);
    #1;
    iWE = we; iSTART = st; iSTAGE_DONE = dn; iENG_WE = eng; iRESET = rs;
    cyc++;
    if (rs) begin
      mPhase = 0; mWords = 0; mStage = 0; mResV = 1'b0; mRdSel = 1'b0;
      mErr = 1'b0; mLaunch = 1'b0;
      expQ.push_back('0);
      return;
    end
    busy = (mPhase == 1) || (mPhase == 2);
    odd  = (mStage % 2) == 1;
    stg  = 2'(mStage);
    e = {((mPhase == 0) && we) || ((mPhase == 1) && eng && odd),
         (mPhase == 1) && eng && !odd,
         busy && odd,
         mRdSel,
         stg,
         busy && (mStage == 0),
         busy && (mStage == ST_NUM - 1),
         mLaunch,
         busy,
         logic'(mWords == FRAME),
         mResV,
         mErr,
         logic'(mPhase == 3)};
    expQ.push_back(e);

    nErr    = ((mPhase == 0) && st && (mWords != FRAME)) || ((mPhase != 0) && we);
    nLaunch = 1'b0;
    case (mPhase)
      0: begin
        if (st && (mWords == FRAME)) begin
          mPhase = 1; mStage = 0; nLaunch = 1'b1;
        end
        if (we) begin
          mWords = (mWords < FRAME) ? mWords + 1 : FRAME;
          mResV  = 1'b0;
        end
      end
      1: if (dn) mPhase = (mStage < ST_NUM - 1) ? 2 : 3;
      2: begin mStage = mStage + 1; mPhase = 1; nLaunch = 1'b1; end
      default: begin
        mPhase = 0; mResV = 1'b1; mWords = 0; mStage = 0;
        mRdSel = logic'((ST_NUM % 2) == 1);
      end
    endcase
    mErr    = nErr;
    mLaunch = nLaunch;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic loadWords(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One stage lasting len cycles with random engine writes, ended by a done pulse.
  task automatic runStage(input int len);
    for (int i = 0; i < len - 1; i++)
      step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  always @(negedge clk) begin
    outVec_t e, a;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      a = packDut();
      nCmp++;
      if (a !== e) begin
        nMis++;
        $display("FAIL outputs cycle %0d: got %b required %b", cyc, a, e);
      end
    end
  end

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idleCycles(2);

    // Premature start, then complete the frame, overfill by one, start.
    loadWords(15);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idleCycles(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Stage 0 with a blocked write and an ignored start inside it.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    runStage(14);
    runStage(20);
    runStage(20);
    idleCycles(2);

    // Done pulse in idle is ignored; a new load drops the result flag.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idleCycles(1);
    loadWords(16);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runStage(20);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in stage 1, then a clean full run.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idleCycles(1);
    loadWords(16);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runStage(20);
    runStage(20);
    runStage(20);
    idleCycles(3);

    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 499) == 0));
    idleCycles(2);

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      nMis++;
      $display("FAIL scoreboard drain: %0d left, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fht_pingpong_ctrl.md
Name: fht_pingpong_ctrl

Overview:
- Top-level sequencer for the FHT core. Owns the two ping-pong RAM blocks (A and B, 4 banks each).
- Gates external frame loading into RAM A and starts the engine. Steps stages by swapping the source and destination RAM blocks, then flags completion.
- Selects which RAM block external readout uses. Sits above the address-generator/control block and the butterfly block, and feeds their stage flags and RAM write enables.

Parameters:
- A_BIT, 8: per-bank address width; frame length FRAME = 4*2^A_BIT words.
- ST_NUM, 5: number of FHT stages per frame (>=2).
- STG_BIT, 3: width of the stage counter; must satisfy 2^STG_BIT >= ST_NUM.

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  asynchronous reset, active-high.
- iWE  in  1  external load write strobe (one frame word per cycle).
- iSTART  in  1  start request, level-sampled each cycle.
- iSTAGE_DONE  in  1  one-cycle pulse from the address generator after the last write of a stage.
- iENG_WE  in  1  engine write enable for the current destination block.
- oWE_A  out  1  write enable to RAM A (all banks).
- oWE_B  out  1  write enable to RAM B.
- oSRC_B  out  1  engine read source: 0 = A, 1 = B.
- oRD_SEL_B  out  1  external readout mux: 0 = A, 1 = B.
- oSTAGE  out  STG_BIT  current stage index.
- oST_ZERO  out  1  high when oSTAGE==0 and busy.
- oST_LAST  out  1  high when oSTAGE==ST_NUM-1 and busy.
- oSTAGE_START  out  1  one-cycle pulse that launches a stage.
- oBUSY  out  1  high in RUN and GAP.
- oLOADED  out  1  full frame present in RAM A.
- oRES_VALID  out  1  result frame readable.
- oERR  out  1  one-cycle pulse on a rejected request.
- oRDY  out  1  one-cycle pulse when the transform finishes.

Behaviour:
- Reset: state IDLE, load count 0, stage 0. Every output is 0, including oRD_SEL_B and oRES_VALID. All outputs are registered except oWE_A and oWE_B.
- States:
  - IDLE: accepts loads and starts.
  - RUN: a stage is in progress.
  - GAP: one cycle between stages.
  - FIN: one cycle that asserts oRDY.
- Loading in IDLE:
  - oWE_A = iWE, combinational; oWE_B = 0.
  - Each iWE increments the load count, saturating at FRAME; oLOADED = (count==FRAME).
  - The first iWE after a result clears oRES_VALID on the next cycle.
- Start in IDLE:
  - iSTART with oLOADED=1 → next cycle RUN, stage 0, oSTAGE_START=1, oBUSY=1.
  - iSTART with oLOADED=0 → oERR pulse; stay in IDLE.
  - The start decision uses the registered count. If iWE and iSTART arrive together at count FRAME-1, the write is counted and the start is rejected.
- RUN:
  - oSRC_B = oSTAGE[0].
  - The destination is the opposite block: oWE_A = iENG_WE & oSRC_B; oWE_B = iENG_WE & ~oSRC_B.
  - On iSTAGE_DONE, if stage < ST_NUM-1 → GAP; else → FIN.
- GAP: stage increments; next cycle RUN with an oSTAGE_START pulse. Latency from iSTAGE_DONE to the next oSTAGE_START is 2 cycles.
- FIN:
  - oRDY=1 for one cycle.
  - Next cycle IDLE with oRES_VALID=1 and the load count cleared (frame consumed).
  - oRD_SEL_B = (ST_NUM odd), i.e. the block written by the last stage. It holds until the next result.
- Ignored or rejected inputs:
  - iWE while oBUSY → blocked (oWE_A=oWE_B=0 from iWE) and oERR pulse.
  - iSTART while busy → ignored, no oERR.
  - iSTAGE_DONE outside RUN → ignored.
  - iENG_WE outside RUN → no RAM write.
- oERR pulses once per offending cycle.
- Reset asserted mid-run returns to IDLE immediately. The RAM contents are then undefined for the user; oLOADED=0 and oRES_VALID=0.

Decomposition:
- Shared package (fht_defines): FRAME and the state encodings (IDLE, RUN, GAP, FIN). A_BIT, ST_NUM and STG_BIT defaults come from the existing defines.
- One natural sub-module: fht_load_cnt, the saturating frame-load counter with its clear and oLOADED flag.
- The FSM and the write-enable routing stay in the top.

Test Plan (A_BIT=2, FRAME=16, ST_NUM=3):
- 16 iWE pulses → oWE_A follows iWE, oLOADED=1 on the cycle after the 16th. A 17th iWE leaves the count at 16.
- iSTART after 15 writes → oERR for 1 cycle, oBUSY stays 0. 16th write then iSTART → oSTAGE_START at t+1, oSTAGE=0, oST_ZERO=1, oSRC_B=0.
- Full run with iSTAGE_DONE at 20-cycle intervals:
  - oSTAGE goes 0,1,2 with oSRC_B=0,1,0.
  - Stage-0 iENG_WE drives oWE_B only; stage-1 drives oWE_A only.
  - oSTAGE_START occurs 2 cycles after each iSTAGE_DONE.
  - oRDY occurs 1 cycle after the final done; then oRD_SEL_B=1, oRES_VALID=1, oLOADED=0.
- During RUN, iWE=1 and iSTART=1 → oWE_A=oWE_B=0 for iWE and oERR pulse; the start is ignored and the stage sequence is unchanged.
- iSTAGE_DONE pulsed in IDLE → no state change. iWE after a result → oRES_VALID drops the next cycle.
- iRESET asserted in stage 1 → all outputs 0 asynchronously. Release, reload 16 words, start → a normal run from stage 0.
